// File: rtl/ks_mul_seq_if.sv
// Operand/result handshake bundle for the sequential Karatsuba GF(2)[x] multiplier.
// The producer side (master) presents operands and accepts results; the
// multiplier itself sits on the slave side.
interface ks_mul_seq_if #(
    parameter int W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            reduce;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-2:0]  d;

    modport master (
        output in_valid, a, b, reduce, out_ready,
        input  in_ready, out_valid, d
    );

    modport slave (
        input  in_valid, a, b, reduce, out_ready,
        output in_ready, out_valid, d
    );
endinterface

// File: rtl/ks_mul_seq.sv
// Time-multiplexed Karatsuba carry-less multiplier over GF(2)[x].
// One H x H carry-less sub-multiplier is reused over three cycles for the
// low, high and middle partial products; a fourth cycle combines them and
// optionally reduces modulo x^W + POLY. Result is held until handshaken.
module ks_mul_seq #(
    parameter int          W    = 32,
    parameter logic [W-1:0] POLY = W'(32'h0000_008D)
) (
    input  logic        clk,
    input  logic        rst_n,
    ks_mul_seq_if.slave bus
);
    localparam int H  = W / 2;
    localparam int PW = 2 * H - 1;   // width of each half-width product
    localparam int DW = 2 * W - 1;   // width of the full product

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            red_q, red_d;
    logic [PW-1:0]   ml_q, ml_d;
    logic [PW-1:0]   mh_q, mh_d;
    logic [PW-1:0]   mm_q, mm_d;
    logic [DW-1:0]   d_q, d_d;
    logic            out_valid_q, out_valid_d;

    logic [H-1:0]    sm_x, sm_y;
    logic [PW-1:0]   sm_p;
    logic [DW-1:0]   full_prod;

    // Carry-less H x H multiply: XOR of shifted copies of x selected by y.
    function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] y);
        logic [PW-1:0] acc;
        acc = '0;
        for (int j = 0; j < H; j++) begin
            if (y[j]) begin
                acc = acc ^ (PW'(x) << j);
            end
        end
        return acc;
    endfunction

    // Long division by f = x^W + POLY from the top bit down; only the
    // remainder survives, so the upper W-1 bits come out zero.
    function automatic logic [DW-1:0] reduce_mod(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int i = DW - 1; i >= W; i--) begin
            if (r[i]) begin
                r    = r ^ (DW'(POLY) << (i - W));
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;

    // Operand mux feeding the single shared sub-multiplier, selected by phase.
    always_comb begin
        sm_x = a_q[H-1:0];
        sm_y = b_q[H-1:0];
        case (state_q)
            MUL_HI: begin
                sm_x = a_q[W-1:H];
                sm_y = b_q[W-1:H];
            end
            MUL_MID: begin
                sm_x = a_q[H-1:0] ^ a_q[W-1:H];
                sm_y = b_q[H-1:0] ^ b_q[W-1:H];
            end
            default: begin
                sm_x = a_q[H-1:0];
                sm_y = b_q[H-1:0];
            end
        endcase
        sm_p = clmul_h(sm_x, sm_y);
    end

    // Karatsuba recombination; the middle term is mM with mL and mH cancelled.
    always_comb begin
        full_prod = DW'(ml_q)
                  ^ (DW'(ml_q ^ mh_q ^ mm_q) << H)
                  ^ (DW'(mh_q) << W);
    end

    // Next-state and datapath register updates for each phase.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        red_d       = red_q;
        ml_d        = ml_q;
        mh_d        = mh_q;
        mm_d        = mm_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    red_d   = bus.reduce;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                ml_d    = sm_p;
                state_d = MUL_HI;
            end
            MUL_HI: begin
                mh_d    = sm_p;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                mm_d    = sm_p;
                state_d = COMBINE;
            end
            COMBINE: begin
                d_d         = red_q ? reduce_mod(full_prod) : full_prod;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            red_q       <= 1'b0;
            ml_q        <= '0;
            mh_q        <= '0;
            mm_q        <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            red_q       <= red_d;
            ml_q        <= ml_d;
            mh_q        <= mh_d;
            mm_q        <= mm_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: doc/ks_mul_seq.md
# ks_mul_seq

Parametrised, time-multiplexed Karatsuba multiplier over GF(2)[x]. Operands are W-bit binary polynomials. The block computes either the full (2W−1)-bit carry-less product or the product reduced modulo x^W + POLY. A single combinational half-width multiplier is reused over three cycles for the low, high and middle Karatsuba products. A valid/ready handshake sits on each side, so the block drops into streaming polynomial-arithmetic datapaths where the fully combinational fixed-width multipliers are too large.

## Interface
- W, default 32: operand width in bits; must be even and ≥ 4.
- POLY, default 32'h0000_008D: low W bits of the reduction polynomial f = x^W + POLY. Bit i is the coefficient of x^i.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A, bit i = coefficient of x^i.
- b  in  W  operand B.
- reduce  in  1  0 = full product; 1 = product mod f. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- d  out  2W−1  result.

## Operation
- All additions are XOR. There are no carries anywhere.
- Halves: H = W/2. aL = a[H−1:0], aH = a[W−1:H], and likewise for b.
- Products, each 2H−1 bits wide:
  - mL = aL·bL
  - mH = aH·bH
  - mM = (aL^aH)·(bL^bH)
- Full product: d = mL ^ ((mL^mH^mM) << H) ^ (mH << W).
- Sub-multiplier: one combinational H×H carry-less multiplier. Its operand inputs are muxed by state. There is exactly one instance.
- Reduce mode:
  - For i = 2W−2 down to W: if bit i of the running value is 1, XOR POLY << (i−W) into it and clear bit i.
  - The result occupies d[W−1:0]; d[2W−2:W] = 0.
  - Reduction is combinational inside the COMBINE cycle.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch a, b and reduce; go to MUL_LO.
  - MUL_LO: register mL; go to MUL_HI.
  - MUL_HI: register mH; go to MUL_MID.
  - MUL_MID: register mM; go to COMBINE.
  - COMBINE: load d (reduced if the latched reduce = 1); set out_valid; go to DONE.
  - DONE: hold d and out_valid until out_valid && out_ready, then clear out_valid and go to IDLE.
- in_ready = 1 only in IDLE. In all other states the a, b and reduce inputs are ignored.
- Operands and mode are latched at acceptance. Input changes after acceptance do not affect the result.

## Timing
- Reset values, asynchronous and immediate:
  - state = IDLE, in_ready = 1, out_valid = 0, d = 0.
  - All internal operand and product registers = 0.
- Acceptance happens at a clock edge E0 where in_valid && in_ready.
- mL is captured at E1, mH at E2, mM at E3.
- d and out_valid = 1 are visible after E4. Latency is 4 cycles.
- Output handshake completes at the first edge with out_valid && out_ready. out_valid is 0 after that edge and in_ready is 1 in the same cycle.
- If out_ready is already high when out_valid rises, the handshake happens at E5 and the earliest next acceptance is E6.
- Maximum throughput is one operation per 6 cycles.
- Backpressure: while out_ready = 0, d and out_valid hold stable indefinitely and in_ready stays 0.
- Reset asserted mid-operation aborts the operation. No result is produced and the output shows reset values until a new operation is accepted after rst_n deasserts.
- If in_valid is high in the reset-release cycle, acceptance occurs at the first rising edge with rst_n = 1.

## Test plan
- W=16, reduce=0, a=16'h0003, b=16'h0003 -> d=31'h0000_0005 after 4 cycles.
- W=16, reduce=0, a=16'hFFFF, b=16'hFFFF -> d=31'h5555_5555. Exercises all carry-less cross terms, including the middle product.
- W=16, POLY=16'h002B, reduce=1, a=16'h8000, b=16'h0002 -> d=31'h0000_002B. Also check reduce=0 with the same operands -> d=31'h0001_0000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises. Required: d stable, in_ready=0, and a second in_valid pulse is ignored. Then raise out_ready -> one handshake, then in_ready=1.
- Reset mid-op: assert rst_n=0 in state MUL_HI. Required: out_valid=0 and d=0 immediately. After release, a new a=16'h0001, b=16'h1234 -> d=31'h0000_1234.
- Randomised back-to-back: 1000 random pairs, random reduce and random out_ready, W=32 default, checked against a bitwise shift-XOR reference model. Required: zero mismatches and no lost or duplicated results.
